// File: rtl/fp_divider_seq.sv
// ---------------------------------------------------------------------------
// fp_divider_seq
// Sequential IEEE-754 style floating-point divider, out = a / b.
// The mantissa quotient is produced by a restoring shift-subtract loop that
// retires one quotient bit per cycle. Results are truncated (round toward
// zero). Subnormal inputs and subnormal results are flushed to zero.
//
// Handshake (one comment for the whole interface):
//   A request is accepted on a rising clk edge where start=1 and the block is
//   idle; a and b are captured on that same edge. start is ignored at any
//   other time and nothing is queued. busy is high from the cycle after
//   acceptance until the result is ready. done is a one-cycle pulse, and out
//   is valid from that cycle and held until the next done.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   division request, sampled only while idle
//   a            in   dividend (W bits)
//   b            in   divisor  (W bits)
//   busy         out  operation in flight
//   done         out  one-cycle completion pulse
//   out          out  quotient (W bits)
//   dbg_state_o  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module fp_divider_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic [2:0]   dbg_state_o
);

    localparam int N_IT  = MAN_W + 2;
    localparam int CNT_W = $clog2(N_IT);
    localparam int EX_W  = EXP_W + 2;

    localparam logic [EX_W-1:0]  BIAS_X   = EX_W'((2 ** (EXP_W - 1)) - 1);
    localparam logic [EX_W-1:0]  EXP_MAX  = EX_W'((2 ** EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SPEC = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_NORM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            state_q, state_d;
    logic                  sign_q,  sign_d;
    logic signed [EX_W-1:0] exp_q,  exp_d;
    logic [MAN_W+1:0]      rem_q,   rem_d;
    logic [MAN_W:0]        mb_q,    mb_d;
    logic [N_IT-1:0]       quo_q,   quo_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  fin_q,   fin_d;
    logic [W-1:0]          spec_q,  spec_d;
    logic [W-1:0]          out_q,   out_d;

    // ------------------------------------------------------------------
    // Operand decode (only meaningful in IDLE, where a/b are captured)
    // ------------------------------------------------------------------
    logic             sa, sb, s_res;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan;
    logic             b_zero, b_inf, b_nan;
    logic             spec_any;
    logic [W-1:0]     spec_res;
    logic [EX_W-1:0]  e_calc;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];
    assign s_res = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    assign spec_any = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    // Priority: NaN-producing cases first, then infinity, then zero.
    always_comb begin
        spec_res = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            spec_res = {s_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_res = {s_res, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end
    end

    // Unsigned arithmetic in EX_W bits wraps exactly like a signed value.
    assign e_calc = {2'b00, ea} - {2'b00, eb} + BIAS_X;

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic             q_bit;
    logic [MAN_W+1:0] rem_sub;
    logic [MAN_W+1:0] rem_step;

    assign q_bit    = (rem_q >= {1'b0, mb_q});
    assign rem_sub  = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    // After a step the remainder is below mb, so the shifted-out bit is 0.
    assign rem_step = rem_sub << 1;

    // ------------------------------------------------------------------
    // Normalisation and range check of the finished quotient
    // ------------------------------------------------------------------
    logic [MAN_W-1:0]       frac_n;
    logic signed [EX_W-1:0] exp_n;
    logic [W-1:0]           norm_res;

    always_comb begin
        // Quotient lies in (0.5, 2): at most a single left shift is needed.
        if (quo_q[N_IT-1]) begin
            frac_n = quo_q[N_IT-2:1];
            exp_n  = exp_q;
        end else begin
            frac_n = quo_q[N_IT-3:0];
            exp_n  = exp_q - EX_W'(1);
        end

        if (exp_n >= $signed(EXP_MAX)) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_n[EX_W-1] || (exp_n == '0)) begin
            norm_res = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else begin
            norm_res = {sign_q, exp_n[EXP_W-1:0], frac_n};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        mb_d    = mb_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        spec_d  = spec_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d = s_res;
                    spec_d = spec_res;
                    if (spec_any) begin
                        state_d = ST_SPEC;
                    end else begin
                        state_d = ST_DIV;
                        exp_d   = $signed(e_calc);
                        rem_d   = {1'b0, 1'b1, fa};
                        mb_d    = {1'b1, fb};
                        quo_d   = '0;
                        cnt_d   = '0;
                        fin_d   = 1'b0;
                    end
                end
            end

            ST_SPEC: begin
                out_d   = spec_q;
                state_d = ST_DONE;
            end

            // N_IT iteration cycles, then one cycle with fin set before NORM.
            ST_DIV: begin
                if (fin_q) begin
                    state_d = ST_NORM;
                end else begin
                    rem_d = rem_step;
                    quo_d = {quo_q[N_IT-2:0], q_bit};
                    if (cnt_q == CNT_LAST) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_NORM: begin
                out_d   = norm_res;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            spec_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            spec_q  <= spec_d;
            out_q   <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (state_q == ST_SPEC) || (state_q == ST_DIV) || (state_q == ST_NORM);
    assign done        = (state_q == ST_DONE);
    assign out         = out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_divider_seq
// Self-checking bench for fp_divider_seq at default parameters (binary32).
// The reference model divides the mantissas with one integer division and
// applies the special-value, truncation and range rules directly.
// ---------------------------------------------------------------------------
module tb_fp_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [2:0]  dbg_state;

  int n_cmp;
  int n_bad;

  fp_divider_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    bit          x0, xi, xn, y0, yi, yn;
    logic [63:0] mx, my, q;
    logic [22:0] frac;
    int          e;
    s  = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    x0 = (ex == 0); xi = (ex == 8'hFF) && (fx == 0); xn = (ex == 8'hFF) && (fx != 0);
    y0 = (ey == 0); yi = (ey == 8'hFF) && (fy == 0); yn = (ey == 8'hFF) && (fy != 0);
    if (xn || yn || (x0 && y0) || (xi && yi)) return 32'h7FC00000;
    if (xi || y0) return {s, 8'hFF, 23'd0};
    if (x0 || yi) return {s, 31'd0};
    mx = {40'd0, 1'b1, fx};
    my = {40'd0, 1'b1, fy};
    q  = (mx << 24) / my;   // 25-bit truncated quotient, bit 24 has weight 1
    e  = int'(ex) - int'(ey) + 127;
    if (q[24]) begin
      frac = q[23:1];
    end else begin
      frac = q[22:0];
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], frac};
  endfunction

  // ---------------- driver ----------------
  // Issues one request from an idle DUT and waits (bounded) for done.
  // lat = cycle of done counted from the accepting edge (-1 on timeout);
  // busy_err counts cycles where busy disagreed with "in flight".
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] res, output int lat, output int busy_err);
    busy_err = 0;
    lat      = -1;
    res      = 32'h0;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        res = out;
        if (busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta [14] = '{32'h41590000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                             32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                             32'h40000000, 32'h7F000000, 32'h00800000, 32'h40C00000,
                             32'h7FC00001, 32'hFFC00000};
    logic [31:0] tb [14] = '{32'h40600000, 32'h40400000, 32'h40400000, 32'h00000000,
                             32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000,
                             32'h7F800000, 32'h00800000, 32'h40000000, 32'h40000000,
                             32'h3F800000, 32'h40000000};
    logic [31:0] tq [14] = '{32'h40780000, 32'h3EAAAAAA, 32'hBEAAAAAA, 32'h7FC00000,
                             32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000,
                             32'h00000000, 32'h7F800000, 32'h00000000, 32'h40400000,
                             32'h7FC00000, 32'h7FC00000};
    logic [31:0] res;
    int lat, berr, exp_lat;
    for (int i = 0; i < 14; i++) begin
      do_op(ta[i], tb[i], res, lat, berr);
      exp_lat = is_special(ta[i], tb[i]) ? 2 : 28;
      n_cmp++;
      if (res !== tq[i]) begin
        n_bad++;
        $display("FAIL directed_out[%0d] %h/%h: got %h, required %h", i, ta[i], tb[i], res, tq[i]);
      end
      n_cmp++;
      if (lat != exp_lat || berr != 0) begin
        n_bad++;
        $display("FAIL directed_timing[%0d]: done at cycle %0d busy_errs %0d, required cycle %0d busy_errs 0",
                 i, lat, berr, exp_lat);
      end
      // done is a single pulse and out holds afterwards.
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || out !== tq[i]) begin
        n_bad++;
        $display("FAIL directed_hold[%0d]: done=%b out=%h, required done=0 out=%h", i, done, out, tq[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y, res, exp_v;
    int lat, berr, exp_lat;
    for (int i = 0; i < 60; i++) begin
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: x[30:23] = 8'h00;
        1: y[30:23] = 8'hFF;
        2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
        3: begin x[30:23] = 8'($urandom_range(200, 254)); y[30:23] = 8'($urandom_range(1, 60)); end
        4: begin x[30:23] = 8'($urandom_range(1, 60)); y[30:23] = 8'($urandom_range(180, 254)); end
        default: ;
      endcase
      exp_v   = model(x, y);
      exp_lat = is_special(x, y) ? 2 : 28;
      do_op(x, y, res, lat, berr);
      n_cmp++;
      if (res !== exp_v || lat != exp_lat || berr != 0) begin
        n_bad++;
        $display("FAIL random[%0d] %h/%h: got %h at cycle %0d (busy_errs %0d), required %h at cycle %0d",
                 i, x, y, res, lat, berr, exp_v, exp_lat);
      end
    end
  endtask

  task automatic test_ignore_start;
    int n_done, first_done;
    logic [31:0] res;
    n_done     = 0;
    first_done = -1;
    res        = 32'h0;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'h40000000;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = n;
          res        = out;
        end
      end
      if (n == 5 || n == 10) begin
        start = 1'b1;
        a     = 32'h3F800000;
        b     = 32'h40400000;
      end else begin
        start = 1'b0;
      end
    end
    n_cmp++;
    if (n_done != 1 || first_done != 28 || res !== 32'h40400000) begin
      n_bad++;
      $display("FAIL ignore_start: %0d done pulses, first at %0d with %h; required 1 at 28 with 40400000",
               n_done, first_done, res);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, idle_cycle_ok;
    logic [31:0] r1, r2, exp2;
    d1 = -1; d2 = -1; r1 = 32'h0; r2 = 32'h0; idle_cycle_ok = 0;
    exp2 = model(32'h3F800000, 32'h40400000);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'h40000000;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 2) begin
        // Only captured at the next acceptance.
        a = 32'h3F800000;
        b = 32'h40400000;
      end
      if (n == 29 && !busy && !done) idle_cycle_ok = 1;
      if (done && d1 < 0) begin
        d1 = n; r1 = out;
      end else if (done && d2 < 0) begin
        d2 = n; r2 = out;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (d1 != 28 || r1 !== 32'h40400000) begin
      n_bad++;
      $display("FAIL back_to_back_first: done at %0d out %h, required 28 and 40400000", d1, r1);
    end
    n_cmp++;
    if (d2 != 57 || r2 !== exp2 || idle_cycle_ok != 1) begin
      n_bad++;
      $display("FAIL back_to_back_second: done at %0d out %h idle_gap %0d, required 57 %h idle_gap 1",
               d2, r2, idle_cycle_ok, exp2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int spurious, lat, berr;
    logic [31:0] res, held;
    spurious = 0;
    held     = out;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1 || out !== held) begin
      n_bad++;
      $display("FAIL mid_div_before_reset: busy=%b out=%h, required 1 %h", busy, out, held);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_div_reset: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL mid_div_no_done: %0d active cycles after reset, required 0", spurious);
    end
    do_op(32'h40C00000, 32'h40000000, res, lat, berr);
    n_cmp++;
    if (res !== 32'h40400000 || lat != 28 || berr != 0) begin
      n_bad++;
      $display("FAIL after_reset_op: got %h at cycle %0d, required 40400000 at cycle 28", res, lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
